mmio_io_hub: RTL and testbench
==============================

// Module: mmio_io_hub
// PURPOSE
//  Parametrised memory-mapped I/O hub between the CPU data port and BRAM port A.
//  Decodes the I/O window, gates BRAM writes, and drives NUM_OUT writable output registers (LED banks).
//  Buffers keyboard scancodes in a FIFO, so keypresses are no longer lost between CPU polls.
//  Replaces the fixed single LED flop / keyboard mux at top level.
// PARAMETERS
//  WIDTH       16  data width of CPU, BRAM and I/O registers
//  ADDR_WIDTH  10  CPU address width; I/O window = addr[ADDR_WIDTH-1:ADDR_WIDTH-2]==2'b11
//  NUM_OUT     2   number of output registers, 1..8, at offsets 0..NUM_OUT-1
//  FIFO_DEPTH  8   keyboard FIFO entries; power of 2, 2..16
// PORTS
//  clk        in   1              system clock; all state updates on posedge
//  reset      in   1              synchronous, active-high
//  cpu_addr   in   ADDR_WIDTH     CPU data address
//  cpu_we     in   1              CPU write enable
//  cpu_wdata  in   WIDTH          CPU write data
//  cpu_rdata  out  WIDTH          read data to CPU (BRAM q or I/O register)
//  mem_q      in   WIDTH          BRAM port A read data
//  mem_we     out  1              BRAM port A write enable = cpu_we & ~io_sel
//  kb_data    in   8              scancode from ps2_keyboard
//  kb_valid   in   1              one-cycle strobe: kb_data valid
//  out_regs   out  NUM_OUT*WIDTH  output registers, reg i at [i*WIDTH +: WIDTH]
//  irq        out  1              keyboard interrupt (MMIO_IRQ_EN only, else 0)
// BEHAVIOUR
//  - io_sel = cpu_addr top two bits == 2'b11; offset = cpu_addr[3:0]; address bits between are ignored.
//  - Read path is combinational: cpu_rdata = io_sel ? io_mux : mem_q, with no added latency.
//  - Register map:
//    - 0..NUM_OUT-1 OUT[i]: read/write.
//    - 0x8 KB_DATA: read-only peek, returns {0, head scancode}, or 0 when empty.
//    - 0x9 KB_STAT: read-only; [15]=full, [14]=empty, [13]=overflow, [12]=irq_en, [4:0]=count.
//    - 0xA KB_CTRL: write-only, reads 0. Bit0=pop, bit1=flush, bit2=clear overflow, bit3=irq_en value.
//  - Unmapped offsets read 0; writes to them are ignored. I/O writes never reach BRAM.
//  - Writes are registered at posedge clk when cpu_we & io_sel, and are visible on the following cycle.
//    cpu_we must be asserted for exactly one cycle per store.
//  - Reads have no side effects, so the multicycle CPU may hold an address safely. Dequeue only via KB_CTRL pop.
//  - FIFO uses rd/wr pointers of log2(FIFO_DEPTH) bits that wrap modulo depth, plus a count of log2+1 bits.
//  - Push on kb_valid:
//    - not full: store kb_data at wr_ptr.
//    - full and no pop in the same cycle: drop the byte and set overflow (sticky).
//  - Pop on an empty FIFO: no-op; pointers do not move.
//  - Pop and push in the same cycle:
//    - count unchanged, both pointers advance.
//    - when full, the pop frees the slot and the push is accepted; no overflow.
//    - when empty, the push is accepted and the pop is ignored; count becomes 1.
//  - Flush: pointers and count go to 0. Flush beats a same-cycle push; that byte is discarded.
//    Flush combined with a pop acts as flush only.
//  - Clear overflow: overflow=0. If an overflow occurs in the same cycle, set wins.
//  - Reset values: out_regs=0, FIFO empty, count=0, overflow=0, irq_en=0, irq=0.
//    Reset mid-operation discards FIFO contents and any same-cycle write.
// CONFIGURATION
//  MMIO_IRQ_EN defined:
//    - irq is registered: irq <= irq_en & (count!=0).
//    - irq falls one cycle after the pop that empties the FIFO.
//  MMIO_IRQ_EN undefined:
//    - irq tied 0; KB_CTRL bit3 ignored; KB_STAT[12] reads 0.
// TESTING
//  - Reset, write 16'hA5A5 to offset 0 and 16'h0F0F to offset 1 -> out_regs={0F0F,A5A5}; mem_we stays 0.
//  - Store to addr 10'h010 -> mem_we=1; read 10'h010 -> cpu_rdata=mem_q. Read 10'h30B -> 0.
//  - Push 8'h1C, 8'h32, then read KB_DATA twice -> 16'h001C both times.
//    Pop -> KB_DATA=16'h0032, KB_STAT[4:0]=1.
//  - Push 9 codes with depth 8 -> full=1, overflow=1, first 8 codes retained in order.
//    Then pop+push in the same cycle -> count stays 8, overflow unchanged.
//  - Fill 3 entries, then flush together with kb_valid -> count=0, empty=1.
//    Then reset with 2 entries queued -> empty, out_regs=0.
//  - MMIO_IRQ_EN: write KB_CTRL=8, push 8'h29 -> irq=1 the next cycle; pop -> irq=0 the next cycle.
//    Without the macro -> irq=0 throughout.

Source files
------------

// File: rtl/mmio_io_hub.sv
// mmio_io_hub: CPU/BRAM memory-mapped I/O hub with output registers and a keyboard scancode FIFO.
// Defining MMIO_IRQ_EN adds the registered keyboard interrupt and the KB_CTRL irq_en bit.
module mmio_io_hub #(
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 10,
    parameter int NUM_OUT    = 2,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ADDR_WIDTH-1:0]    cpu_addr,
    input  logic                     cpu_we,
    input  logic [WIDTH-1:0]         cpu_wdata,
    output logic [WIDTH-1:0]         cpu_rdata,
    input  logic [WIDTH-1:0]         mem_q,
    output logic                     mem_we,
    input  logic [7:0]               kb_data,
    input  logic                     kb_valid,
    output logic [NUM_OUT*WIDTH-1:0] out_regs,
    output logic                     irq
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [3:0]       OFF_KB_DATA = 4'h8;
    localparam logic [3:0]       OFF_KB_STAT = 4'h9;
    localparam logic [3:0]       OFF_KB_CTRL = 4'hA;
    localparam logic [3:0]       NUM_OUT_L   = NUM_OUT[3:0];
    localparam logic [CNT_W-1:0] DEPTH_L     = FIFO_DEPTH[CNT_W-1:0];
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE     = PTR_W'(1);

    logic                     io_sel_s;
    logic [3:0]               offset_s;
    logic                     io_wr_s;
    logic                     ctrl_wr_s;
    logic                     pop_req_s;
    logic                     flush_s;
    logic                     clr_ovf_s;
    logic                     full_s;
    logic                     empty_s;
    logic                     do_pop_s;
    logic                     do_push_s;
    logic                     ovf_set_s;
    logic                     irq_en_s;
    logic [WIDTH-1:0]         stat_s;
    logic [WIDTH-1:0]         io_rdata_s;
    logic [PTR_W-1:0]         wr_ptr_r;
    logic [PTR_W-1:0]         rd_ptr_r;
    logic [CNT_W-1:0]         count_r;
    logic                     ovf_r;
    logic [7:0]               fifo_mem_r [FIFO_DEPTH];
    logic [NUM_OUT*WIDTH-1:0] out_regs_r;
    logic                     unused_s;

    assign io_sel_s  = (cpu_addr[ADDR_WIDTH-1 -: 2] == 2'b11);
    assign offset_s  = cpu_addr[3:0];
    assign unused_s  = ^cpu_addr[ADDR_WIDTH-3:4];
    assign io_wr_s   = cpu_we & io_sel_s;
    assign mem_we    = cpu_we & ~io_sel_s;
    assign ctrl_wr_s = io_wr_s & (offset_s == OFF_KB_CTRL);
    assign pop_req_s = ctrl_wr_s & cpu_wdata[0];
    assign flush_s   = ctrl_wr_s & cpu_wdata[1];
    assign clr_ovf_s = ctrl_wr_s & cpu_wdata[2];
    assign full_s    = (count_r == DEPTH_L);
    assign empty_s   = (count_r == {CNT_W{1'b0}});

    // Flush overrides everything; a pop on a full FIFO frees room for a same-cycle push.
    assign do_pop_s  = pop_req_s & ~empty_s & ~flush_s;
    assign do_push_s = kb_valid & ~flush_s & (~full_s | do_pop_s);
    assign ovf_set_s = kb_valid & ~flush_s & full_s & ~do_pop_s;

    // Keyboard status word
    always_comb begin
        stat_s      = {WIDTH{1'b0}};
        stat_s[15]  = full_s;
        stat_s[14]  = empty_s;
        stat_s[13]  = ovf_r;
        stat_s[12]  = irq_en_s;
        stat_s[4:0] = 5'(count_r);
    end

    // I/O register read mux
    always_comb begin
        io_rdata_s = {WIDTH{1'b0}};
        if (offset_s < NUM_OUT_L) begin
            io_rdata_s = out_regs_r[int'(offset_s)*WIDTH +: WIDTH];
        end else begin
            case (offset_s)
                OFF_KB_DATA: begin
                    if (empty_s) begin
                        io_rdata_s = {WIDTH{1'b0}};
                    end else begin
                        io_rdata_s = {{(WIDTH-8){1'b0}}, fifo_mem_r[rd_ptr_r]};
                    end
                end
                OFF_KB_STAT: io_rdata_s = stat_s;
                default:     io_rdata_s = {WIDTH{1'b0}};
            endcase
        end
    end

    assign cpu_rdata = io_sel_s ? io_rdata_s : mem_q;

    // Output register writes
    always_ff @(posedge clk) begin
        if (reset) begin
            out_regs_r <= {(NUM_OUT*WIDTH){1'b0}};
        end else begin
            for (int i = 0; i < NUM_OUT; i++) begin
                if (io_wr_s && (offset_s == 4'(i))) begin
                    out_regs_r[i*WIDTH +: WIDTH] <= cpu_wdata;
                end
            end
        end
    end

    assign out_regs = out_regs_r;

    // FIFO storage; contents are don't-care once the pointers are reset
    always_ff @(posedge clk) begin
        if (!reset && do_push_s) begin
            fifo_mem_r[wr_ptr_r] <= kb_data;
        end
    end

    // FIFO pointers, occupancy and sticky overflow
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            ovf_r    <= 1'b0;
        end else begin
            if (flush_s) begin
                wr_ptr_r <= {PTR_W{1'b0}};
                rd_ptr_r <= {PTR_W{1'b0}};
                count_r  <= {CNT_W{1'b0}};
            end else begin
                if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
                if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
                case ({do_push_s, do_pop_s})
                    2'b10:   count_r <= count_r + CNT_ONE;
                    2'b01:   count_r <= count_r - CNT_ONE;
                    default: count_r <= count_r;
                endcase
            end
            if (ovf_set_s) begin
                ovf_r <= 1'b1;
            end else if (clr_ovf_s) begin
                ovf_r <= 1'b0;
            end
        end
    end

`ifdef MMIO_IRQ_EN
    logic irq_en_r;
    logic irq_r;

    // Interrupt enable and registered level interrupt
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_en_r <= 1'b0;
            irq_r    <= 1'b0;
        end else begin
            irq_r <= irq_en_r & ~empty_s;
            if (ctrl_wr_s) begin
                irq_en_r <= cpu_wdata[3];
            end
        end
    end

    assign irq_en_s = irq_en_r;
    assign irq      = irq_r;
`else
    assign irq_en_s = 1'b0;
    assign irq      = 1'b0;
`endif
endmodule

// File: tb/tb_mmio_io_hub.sv
// Scoreboard bench for mmio_io_hub: a queue-based reference model predicts every cycle's outputs,
// a separate monitor compares them. Follows MMIO_IRQ_EN when defined.
module tb_mmio_io_hub;
    localparam int WIDTH      = 16;
    localparam int ADDR_WIDTH = 10;
    localparam int NUM_OUT    = 2;
    localparam int FIFO_DEPTH = 8;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [ADDR_WIDTH-1:0]    cpu_addr;
    logic                     cpu_we;
    logic [WIDTH-1:0]         cpu_wdata;
    logic [WIDTH-1:0]         cpu_rdata;
    logic [WIDTH-1:0]         mem_q;
    logic                     mem_we;
    logic [7:0]               kb_data;
    logic                     kb_valid;
    logic [NUM_OUT*WIDTH-1:0] out_regs;
    logic                     irq;

    mmio_io_hub #(
        .WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .NUM_OUT(NUM_OUT), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_we(cpu_we),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .mem_q(mem_q), .mem_we(mem_we),
        .kb_data(kb_data), .kb_valid(kb_valid), .out_regs(out_regs), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0]         rdata;
        logic                     mem_we;
        logic [NUM_OUT*WIDTH-1:0] outs;
        logic                     irq;
        int                       stepn;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   step_no  = 0;

    // Reference model state: FIFO as a byte queue, registers as plain variables
    logic [7:0]       m_q[$];
    logic [WIDTH-1:0] m_out[NUM_OUT];
    bit               m_ovf;
    bit               m_irq_en;
    bit               m_irq;

    function automatic void chk(string name, int stepn, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d actual=%h expected=%h", name, stepn, act, exp);
        end
    endfunction

    function automatic logic [WIDTH-1:0] model_read(logic [ADDR_WIDTH-1:0] a, logic [WIDTH-1:0] mq);
        logic [WIDTH-1:0] r;
        int off;
        r = '0;
        off = int'(a[3:0]);
        if (a[ADDR_WIDTH-1 -: 2] != 2'b11) begin
            r = mq;
        end else if (off < NUM_OUT) begin
            r = m_out[off];
        end else if (off == 8) begin
            if (m_q.size() > 0) r = {8'h00, m_q[0]};
        end else if (off == 9) begin
            r[15]  = (m_q.size() == FIFO_DEPTH);
            r[14]  = (m_q.size() == 0);
            r[13]  = m_ovf;
            r[12]  = m_irq_en;
            r[4:0] = 5'(m_q.size());
        end
        return r;
    endfunction

    task automatic model_edge(input bit rst, input logic [ADDR_WIDTH-1:0] a, input bit we,
                              input logic [WIDTH-1:0] wd, input bit kbv, input logic [7:0] kbd);
        bit io, ctrl, ovf_set;
        int off, old_size;
        bit old_en;
        old_size = m_q.size();
        old_en   = m_irq_en;
        if (rst) begin
            m_q.delete();
            foreach (m_out[i]) m_out[i] = '0;
            m_ovf = 0; m_irq_en = 0; m_irq = 0;
            return;
        end
        io   = (a[ADDR_WIDTH-1 -: 2] == 2'b11);
        off  = int'(a[3:0]);
        ctrl = we && io && (off == 10);
        if (we && io && off < NUM_OUT) m_out[off] = wd;
        ovf_set = 0;
        if (ctrl && wd[1]) begin
            m_q.delete();
        end else begin
            if (ctrl && wd[0] && m_q.size() > 0) void'(m_q.pop_front());
            if (kbv) begin
                if (m_q.size() < FIFO_DEPTH) m_q.push_back(kbd);
                else ovf_set = 1;
            end
        end
        if (ovf_set) m_ovf = 1;
        else if (ctrl && wd[2]) m_ovf = 0;
`ifdef MMIO_IRQ_EN
        m_irq = old_en && (old_size != 0);
        if (ctrl) m_irq_en = wd[3];
`endif
    endtask

    // One clock of stimulus: drive, record expectation, advance the model
    task automatic step(input bit rst, input logic [ADDR_WIDTH-1:0] a, input bit we,
                        input logic [WIDTH-1:0] wd, input bit kbv, input logic [7:0] kbd);
        exp_t e;
        logic [WIDTH-1:0] mq;
        @(negedge clk);
        mq = WIDTH'($urandom);
        reset = rst; cpu_addr = a; cpu_we = we; cpu_wdata = wd;
        mem_q = mq; kb_valid = kbv; kb_data = kbd;
        e.rdata  = model_read(a, mq);
        e.mem_we = we && (a[ADDR_WIDTH-1 -: 2] != 2'b11);
        for (int i = 0; i < NUM_OUT; i++) e.outs[i*WIDTH +: WIDTH] = m_out[i];
        e.irq    = m_irq;
        e.stepn  = step_no;
        sb.push_back(e);
        step_no++;
        model_edge(rst, a, we, wd, kbv, kbd);
    endtask

    task automatic idle(input logic [ADDR_WIDTH-1:0] a);
        step(1'b0, a, 1'b0, 16'h0000, 1'b0, 8'h00);
    endtask

    task automatic push(input logic [7:0] code);
        step(1'b0, 10'h309, 1'b0, 16'h0000, 1'b1, code);
    endtask

    task automatic ctrl(input logic [WIDTH-1:0] wd, input bit kbv, input logic [7:0] kbd);
        step(1'b0, 10'h30A, 1'b1, wd, kbv, kbd);
    endtask

    // Monitor: compare every presented cycle against the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("cpu_rdata", e.stepn, 64'(cpu_rdata), 64'(e.rdata));
                chk("mem_we",    e.stepn, 64'(mem_we),    64'(e.mem_we));
                chk("out_regs",  e.stepn, 64'(out_regs),  64'(e.outs));
                chk("irq",       e.stepn, 64'(irq),       64'(e.irq));
            end
        end
    end

    initial begin
        logic [ADDR_WIDTH-1:0] a;
        logic [WIDTH-1:0]      wd;
        bit                    we, kbv, rst;
        int                    kind;
        reset = 1'b1; cpu_addr = '0; cpu_we = 1'b0; cpu_wdata = '0;
        mem_q = '0; kb_valid = 1'b0; kb_data = '0;

        step(1'b1, 10'h300, 1'b0, 16'h0000, 1'b0, 8'h00);
        step(1'b1, 10'h309, 1'b0, 16'h0000, 1'b0, 8'h00);
        idle(10'h309);
        // Output registers
        step(1'b0, 10'h300, 1'b1, 16'hA5A5, 1'b0, 8'h00);
        step(1'b0, 10'h301, 1'b1, 16'h0F0F, 1'b0, 8'h00);
        idle(10'h300);
        idle(10'h3F1);
        // BRAM path and unmapped offset
        step(1'b0, 10'h010, 1'b1, 16'h1234, 1'b0, 8'h00);
        idle(10'h010);
        idle(10'h30B);
        // Peek without side effects, then pop
        push(8'h1C);
        push(8'h32);
        idle(10'h308);
        idle(10'h308);
        ctrl(16'h0001, 1'b0, 8'h00);
        idle(10'h308);
        idle(10'h309);
        ctrl(16'h0001, 1'b0, 8'h00);
        // Overflow with 9 pushes, then pop+push while full
        for (int i = 0; i < 9; i++) push(8'h40 + 8'(i));
        idle(10'h309);
        idle(10'h308);
        ctrl(16'h0001, 1'b1, 8'h77);
        idle(10'h309);
        ctrl(16'h0004, 1'b0, 8'h00);
        idle(10'h309);
        // Flush with a same-cycle push
        ctrl(16'h0002, 1'b0, 8'h00);
        push(8'h11); push(8'h12); push(8'h13);
        ctrl(16'h0002, 1'b1, 8'h14);
        idle(10'h309);
        // Pop+push on empty
        ctrl(16'h0001, 1'b1, 8'h55);
        idle(10'h308);
        // Reset with entries queued
        push(8'h21);
        step(1'b1, 10'h309, 1'b0, 16'h0000, 1'b1, 8'h22);
        idle(10'h309);
        idle(10'h300);
        // Interrupt sequence
        ctrl(16'h0008, 1'b0, 8'h00);
        push(8'h29);
        idle(10'h309);
        idle(10'h309);
        ctrl(16'h0009, 1'b0, 8'h00);
        idle(10'h309);
        idle(10'h309);

        // Randomised traffic
        for (int n = 0; n < 3000; n++) begin
            rst  = ($urandom_range(0, 299) == 0);
            kbv  = ($urandom_range(0, 5) == 0);
            kind = $urandom_range(0, 9);
            we   = 1'b0;
            wd   = WIDTH'($urandom);
            if (kind < 2) begin
                a  = {2'($urandom_range(0, 2)), 8'($urandom)};
                we = $urandom_range(0, 1);
            end else if (kind < 4) begin
                a  = {2'b11, 4'($urandom), 4'($urandom_range(0, 3))};
                we = 1'b1;
            end else if (kind < 6) begin
                a  = {2'b11, 4'($urandom), 4'hA};
                we = 1'b1;
                wd = '0;
                wd[0] = ($urandom_range(0, 9) < 7);
                wd[1] = ($urandom_range(0, 9) == 0);
                wd[2] = ($urandom_range(0, 3) == 0);
                wd[3] = ($urandom_range(0, 3) != 0);
            end else begin
                a  = {2'b11, 4'($urandom), 4'($urandom)};
            end
            step(rst, a, we, wd, kbv, 8'($urandom));
        end
        idle(10'h309);

        repeat (4) @(negedge clk);
        #3;
        chk("scoreboard_drained", step_no, 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
